serv_mem_serdes: RTL and testbench
==================================

Name: serv_mem_serdes

Overview:
- Parametrised serial-to-bus load/store engine for the SERV core; successor to the single-bit combinational memory interface.
- Collects store data from the core W bits per cycle, aligns it into byte lanes and runs one Wishbone data cycle.
- For loads, it captures the bus word, aligns it, and returns it to the core W bits per cycle with zero or sign extension.
- Sits between the core's bufreg/rd datapath and the data-bus Wishbone master port. Bus address generation is handled elsewhere.

Parameters:
- W, default 1: datapath bits per cycle; legal values 1, 2, 4, 8. N = 32/W beats per word.
- WITH_CSR, default 1: when 1, misaligned accesses trap instead of reaching the bus.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  begin operation; sampled only in IDLE
- i_we  in  1  1 = store, 0 = load
- i_signed  in  1  sign-extend loads
- i_word  in  1  32-bit access
- i_half  in  1  16-bit access; byte access when both i_word and i_half are 0
- i_lsb  in  2  address bits [1:0]
- i_dat  in  W  serial store data, LSB-first
- o_rd  out  W  serial load data, LSB-first
- o_rd_valid  out  1  o_rd beat valid
- o_busy  out  1  FSM not IDLE
- o_done  out  1  one-cycle completion pulse
- o_trap  out  1  one-cycle misalign-trap pulse
- o_misalign  out  1  combinational misalign flag
- o_wb_cyc  out  1  bus request; also used as stb
- o_wb_we  out  1  bus write enable
- o_wb_sel  out  4  byte-lane enables
- o_wb_dat  out  32  write data
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  bus acknowledge

Behaviour:
- Reset: state IDLE, counter 0. o_rd_valid, o_busy, o_done, o_trap, o_wb_cyc and o_wb_we are all 0. o_rd and the data buffer are 0.
- Reset mid-operation: state returns to IDLE at the same edge. o_wb_cyc drops in the next cycle. No o_done is issued.
- o_misalign: WITH_CSR & ((lsb[0] & (word|half)) | (lsb[1] & word)).
  - Combinational from the i_* inputs in IDLE, and from the latched controls otherwise.
- o_wb_sel: computed from the latched controls.
  - sel[3] = lsb==3 | word | (half & lsb[1])
  - sel[2] = lsb==2 | word
  - sel[1] = lsb==1 | word | (half & !lsb[1])
  - sel[0] = lsb==0
- States: IDLE, SHIFT_IN, BUS, SHIFT_OUT, DONE.
- IDLE:
  - On i_start, latch we, signed, word, half and lsb, and clear the counter.
  - If misaligned, go to DONE with the trap flag set.
  - Otherwise go to SHIFT_IN if we=1, else to BUS.
- SHIFT_IN: one beat per cycle, no stall.
  - buf[cnt*W +: W] <= i_dat; cnt increments.
  - After beat N-1, go to BUS.
- BUS:
  - o_wb_cyc = 1; o_wb_we = latched we.
  - o_wb_dat = buf << (8*lsb), with upper bits dropped. It must be stable while o_wb_cyc is high.
  - Wait indefinitely for i_wb_ack.
  - On ack with a store, go to DONE.
  - On ack with a load, buf <= i_wb_rdt >> (8*lsb), clear the counter, and go to SHIFT_OUT.
  - o_wb_cyc is deasserted in the cycle after ack.
- SHIFT_OUT: N cycles, o_rd_valid = 1.
  - Bit j of o_rd is buf[k] when k < size, else (signed & buf[size-1]), where k = cnt*W + j.
  - size is 8, 16 or 32 for byte, half and word.
  - After beat N-1, go to DONE.
- DONE: for one cycle, o_done = 1, and o_trap = 1 if the trap flag is set. Then return to IDLE.
- Timing, with start at cycle 0:
  - Store: SHIFT_IN in cycles 1..N, cyc from N+1, ack at cycle A, done at A+1.
  - Load: cyc from cycle 1, ack at A, beats in A+1..A+N, done at A+N+1.
  - Trap: o_trap and o_done in cycle 1, with no bus cycle.
- Edge cases:
  - i_start while busy is ignored.
  - i_wb_ack outside BUS is ignored.
  - An ack in the first BUS cycle (zero-wait) is legal.
- o_busy = (state != IDLE).

Test Plan:
- W=1, SW at lsb=0 with serial 0xDEADBEEF: 32 SHIFT_IN cycles, then cyc=1, we=1, sel=0xF, dat=0xDEADBEEF. Ack after 3 cycles gives o_done one cycle after ack.
- W=4, LB signed at lsb=2 with rdt=0x0080_0000: 8 beats of o_rd, reassembling 0xFFFFFF80. With signed=0 the result is 0x00000080.
- W=8, SH at lsb=2 with store data 0x1234: sel=0xC, dat=0x12340000. LHU of rdt=0xBEEF0000 gives 0x0000BEEF.
- WITH_CSR=1, LW at lsb=2: o_misalign=1 and o_trap/o_done in cycle 1, o_wb_cyc never rises. With WITH_CSR=0 the bus cycle occurs.
- Assert i_rst while in BUS: cyc=0 next cycle, no o_done. A fresh i_start then works normally. Ack while IDLE, and i_start while busy, both have no effect.
- W=2, LW with zero-wait ack: beats begin the cycle after ack. 16 valid beats, then o_done.

Source files
------------

// File: rtl/serv_mem_serdes.sv
// Serial <-> Wishbone load/store engine for SERV.
// Gathers W-bit store beats into a word, runs one bus cycle, streams loads back.
module serv_mem_serdes #(
    parameter int W        = 1,
    parameter int WITH_CSR = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_we,
    input  logic          i_signed,
    input  logic          i_word,
    input  logic          i_half,
    input  logic [1:0]    i_lsb,
    input  logic [W-1:0]  i_dat,
    output logic [W-1:0]  o_rd,
    output logic          o_rd_valid,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_trap,
    output logic          o_misalign,
    output logic          o_wb_cyc,
    output logic          o_wb_we,
    output logic [3:0]    o_wb_sel,
    output logic [31:0]   o_wb_dat,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack
);

    localparam int N = 32 / W;
    localparam logic [4:0] LAST = 5'(N - 1);
    localparam logic [4:0] WB   = 5'(W);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        BUS,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic        word_q, word_d;
    logic        half_q, half_d;
    logic [1:0]  lsb_q, lsb_d;
    logic        trap_q, trap_d;

    logic        c_word, c_half;
    logic [1:0]  c_lsb;
    logic [4:0]  base;
    logic [5:0]  size;
    logic        ext;

    // Misalignment looks at live inputs until the request is latched
    always_comb begin
        c_word = (state_q == IDLE) ? i_word : word_q;
        c_half = (state_q == IDLE) ? i_half : half_q;
        c_lsb  = (state_q == IDLE) ? i_lsb  : lsb_q;
        o_misalign = (WITH_CSR != 0)
                   & ((c_lsb[0] & (c_word | c_half)) | (c_lsb[1] & c_word));
    end

    assign o_wb_sel[3] = (lsb_q == 2'd3) | word_q | (half_q & lsb_q[1]);
    assign o_wb_sel[2] = (lsb_q == 2'd2) | word_q;
    assign o_wb_sel[1] = (lsb_q == 2'd1) | word_q | (half_q & ~lsb_q[1]);
    assign o_wb_sel[0] = (lsb_q == 2'd0);

    assign o_wb_dat   = data_q << {lsb_q, 3'b000};
    assign o_wb_cyc   = (state_q == BUS);
    assign o_wb_we    = o_wb_cyc & we_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_trap     = o_done & trap_q;
    assign o_rd_valid = (state_q == SHIFT_OUT);

    assign base = cnt_q * WB;
    assign size = word_q ? 6'd32 : (half_q ? 6'd16 : 6'd8);
    assign ext  = signed_q & data_q[5'(size - 6'd1)];

    // Bits past the access size are filled with the extension bit
    always_comb begin
        logic [5:0] k;
        k    = '0;
        o_rd = '0;
        if (o_rd_valid) begin
            for (int j = 0; j < W; j++) begin
                k = {1'b0, base} + 6'(j);
                o_rd[j] = (k < size) ? data_q[k[4:0]] : ext;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        we_d     = we_q;
        signed_d = signed_q;
        word_d   = word_q;
        half_d   = half_q;
        lsb_d    = lsb_q;
        trap_d   = trap_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    we_d     = i_we;
                    signed_d = i_signed;
                    word_d   = i_word;
                    half_d   = i_half;
                    lsb_d    = i_lsb;
                    cnt_d    = '0;
                    trap_d   = o_misalign;
                    if (o_misalign) state_d = DONE;
                    else if (i_we)  state_d = SHIFT_IN;
                    else            state_d = BUS;
                end
            end
            SHIFT_IN: begin
                data_d[base +: W] = i_dat;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else begin
                        data_d  = i_wb_rdt >> {lsb_q, 3'b000};
                        cnt_d   = '0;
                        state_d = SHIFT_OUT;
                    end
                end
            end
            SHIFT_OUT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            word_q   <= 1'b0;
            half_q   <= 1'b0;
            lsb_q    <= '0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            word_q   <= word_d;
            half_q   <= half_d;
            lsb_q    <= lsb_d;
            trap_q   <= trap_d;
        end
    end

endmodule

// File: tb/tb_serv_mem_serdes.sv
// Bench for serv_mem_serdes: five instances (W=1,2,4,8 trapping, W=8 non-trapping)
// driven one at a time from a vector table, hand sequences and random traffic.
module tb_serv_mem_serdes;

    localparam int NI = 5;
    localparam int WS[NI] = '{1, 2, 4, 8, 8};
    localparam int CS[NI] = '{1, 1, 1, 1, 0};

    typedef struct {
        int        idx;
        bit        we;
        bit        sg;
        bit        wd;
        bit        hf;
        bit [1:0]  lb;
        bit [31:0] sdat;
        bit [31:0] rdt;
        int        ackd;
        bit        exp_mis;
        bit        chk_sel;
        bit [3:0]  exp_sel;
        bit [31:0] exp_dat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        we_s;
    logic        sgn;
    logic        word;
    logic        half;
    logic [1:0]  lsb;
    logic [7:0]  dat;
    logic [31:0] rdt;
    logic        ack;
    int          cur;

    logic [7:0]  rd_v   [NI];
    logic [31:0] wdat_v [NI];
    logic [3:0]  sel_v  [NI];
    logic [NI-1:0] rdv_v, busy_v, done_v, trap_v, mis_v, cyc_v, wwe_v;

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [WS[g]-1:0] rdw;
        serv_mem_serdes #(.W(WS[g]), .WITH_CSR(CS[g])) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_start    (start && (cur == g)),
            .i_we       (we_s),
            .i_signed   (sgn),
            .i_word     (word),
            .i_half     (half),
            .i_lsb      (lsb),
            .i_dat      (dat[WS[g]-1:0]),
            .o_rd       (rdw),
            .o_rd_valid (rdv_v[g]),
            .o_busy     (busy_v[g]),
            .o_done     (done_v[g]),
            .o_trap     (trap_v[g]),
            .o_misalign (mis_v[g]),
            .o_wb_cyc   (cyc_v[g]),
            .o_wb_we    (wwe_v[g]),
            .o_wb_sel   (sel_v[g]),
            .o_wb_dat   (wdat_v[g]),
            .i_wb_rdt   (rdt),
            .i_wb_ack   (ack && (cur == g))
        );
        assign rd_v[g] = 8'(rdw);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut %0d): got %h want %h", name, cur, act, exp);
        end
    endtask

    function automatic bit [31:0] model_load(bit [31:0] r, bit [1:0] lb,
                                             int bytes, bit sg);
        longint v;
        longint m;
        int sz;
        sz = 8 * bytes;
        v  = longint'(r >> (8 * lb));
        m  = (64'sd1 <<< sz) - 1;
        v  = v & m;
        if (sg && v[sz-1]) v = v | ~m;
        return 32'(v);
    endfunction

    task automatic scramble();
        we_s = 1'($urandom);
        sgn  = 1'($urandom);
        word = 1'($urandom);
        half = 1'($urandom);
        lsb  = 2'($urandom);
        dat  = 8'($urandom);
    endtask

    task automatic run_op(vec_t v, bit noise);
        int w;
        int n;
        bit [31:0] got;
        w   = WS[v.idx];
        n   = 32 / w;
        got = '0;
        cur = v.idx;
        start = 1'b1;
        we_s  = v.we;
        sgn   = v.sg;
        word  = v.wd;
        half  = v.hf;
        lsb   = v.lb;
        ack   = 1'b0;
        @(negedge clk);
        chk("mis_idle", 32'(mis_v[v.idx]), 32'(v.exp_mis));
        chk("idle_busy", 32'(busy_v[v.idx]), 0);
        tick();
        if (v.exp_mis) begin
            start = 1'b0;
            @(negedge clk);
            chk("trap_done", 32'(done_v[v.idx]), 1);
            chk("trap_flag", 32'(trap_v[v.idx]), 1);
            chk("trap_cyc", 32'(cyc_v[v.idx]), 0);
            tick();
            @(negedge clk);
            chk("trap_idle", 32'(busy_v[v.idx]), 0);
            chk("trap_pulse", 32'(trap_v[v.idx]), 0);
            tick();
            return;
        end
        if (noise) scramble();
        if (v.we) begin
            for (int b = 0; b < n; b++) begin
                dat = 8'(v.sdat >> (b * w));
                if (noise) begin
                    ack = 1'b1;
                    scramble();
                    dat = 8'(v.sdat >> (b * w));
                end
                @(negedge clk);
                chk("shift_cyc", 32'(cyc_v[v.idx]), 0);
                chk("shift_busy", 32'(busy_v[v.idx]), 1);
                tick();
            end
            ack = 1'b0;
        end
        for (int d = 0; d <= v.ackd; d++) begin
            ack = (d == v.ackd);
            rdt = (d == v.ackd) ? v.rdt : $urandom;
            if (noise) scramble();
            @(negedge clk);
            chk("bus_cyc", 32'(cyc_v[v.idx]), 1);
            chk("bus_we", 32'(wwe_v[v.idx]), 32'(v.we));
            if (v.chk_sel) chk("bus_sel", 32'(sel_v[v.idx]), 32'(v.exp_sel));
            if (v.we) chk("bus_wdat", wdat_v[v.idx], v.exp_dat);
            tick();
        end
        ack = 1'b0;
        rdt = $urandom;
        if (!v.we) begin
            for (int b = 0; b < n; b++) begin
                if (noise) begin
                    scramble();
                    ack = 1'b1;
                end
                @(negedge clk);
                chk("rd_valid", 32'(rdv_v[v.idx]), 1);
                chk("rd_cyc", 32'(cyc_v[v.idx]), 0);
                got = got | (32'(rd_v[v.idx]) << (b * w));
                tick();
            end
            chk("load_data", got, v.exp_dat);
        end
        start = 1'b0;
        ack   = 1'b0;
        @(negedge clk);
        chk("done", 32'(done_v[v.idx]), 1);
        chk("done_trap", 32'(trap_v[v.idx]), 0);
        chk("done_cyc", 32'(cyc_v[v.idx]), 0);
        chk("mis_latched", 32'(mis_v[v.idx]), 32'(v.exp_mis));
        tick();
        @(negedge clk);
        chk("after_busy", 32'(busy_v[v.idx]), 0);
        chk("after_done", 32'(done_v[v.idx]), 0);
        tick();
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        tbl[0]  = '{0, 1, 0, 1, 0, 0, 32'hDEADBEEF, 0, 3, 0, 1, 4'hF, 32'hDEADBEEF};
        tbl[1]  = '{2, 0, 1, 0, 0, 2, 0, 32'h00800000, 1, 0, 1, 4'h4, 32'hFFFFFF80};
        tbl[2]  = '{2, 0, 0, 0, 0, 2, 0, 32'h00800000, 1, 0, 1, 4'h4, 32'h00000080};
        tbl[3]  = '{3, 1, 0, 0, 1, 2, 32'h00001234, 0, 0, 0, 1, 4'hC, 32'h12340000};
        tbl[4]  = '{3, 0, 0, 0, 1, 2, 0, 32'hBEEF0000, 2, 0, 1, 4'hC, 32'h0000BEEF};
        tbl[5]  = '{3, 0, 0, 1, 0, 2, 0, 32'h11111111, 0, 1, 0, 4'h0, 32'h0};
        tbl[6]  = '{4, 0, 0, 1, 0, 2, 0, 32'hA5A51234, 1, 0, 1, 4'hE, 32'h0000A5A5};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 0, 32'h89ABCDEF, 0, 0, 1, 4'hF, 32'h89ABCDEF};
        tbl[8]  = '{0, 1, 0, 0, 0, 3, 32'h000000AB, 0, 1, 0, 1, 4'h8, 32'hAB000000};
        tbl[9]  = '{1, 0, 1, 0, 1, 0, 0, 32'h00008001, 2, 0, 1, 4'h3, 32'hFFFF8001};
        tbl[10] = '{2, 1, 0, 0, 1, 1, 32'hCAFEF00D, 0, 0, 1, 0, 4'h0, 32'h0};

        rst = 1'b1;
        start = 1'b0;
        we_s = 1'b0;
        sgn = 1'b0;
        word = 1'b0;
        half = 1'b0;
        lsb = '0;
        dat = '0;
        rdt = '0;
        ack = 1'b0;
        cur = 0;
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            cur = i;
            chk("rst_busy", 32'(busy_v[i]), 0);
            chk("rst_cyc", 32'(cyc_v[i]), 0);
            chk("rst_we", 32'(wwe_v[i]), 0);
            chk("rst_done", 32'(done_v[i] | trap_v[i] | rdv_v[i]), 0);
            chk("rst_rd", 32'(rd_v[i]), 0);
            chk("rst_wdat", wdat_v[i], 0);
        end
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) run_op(tbl[i], 1'b0);

        // Stray ack while idle
        cur = 0;
        ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_ack_busy", 32'(busy_v[0]), 0);
            chk("idle_ack_cyc", 32'(cyc_v[0]), 0);
            tick();
        end
        ack = 1'b0;

        // Reset while the bus cycle is open
        cur = 2;
        start = 1'b1;
        we_s = 1'b0;
        word = 1'b1;
        half = 1'b0;
        lsb = 2'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_cyc", 32'(cyc_v[2]), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_bus_cyc", 32'(cyc_v[2]), 0);
            chk("rst_bus_busy", 32'(busy_v[2]), 0);
            chk("rst_bus_done", 32'(done_v[2]), 0);
            tick();
        end
        run_op(tbl[1], 1'b0);

        // Start held and controls toggling while busy
        run_op(tbl[0], 1'b1);
        run_op(tbl[1], 1'b1);
        run_op(tbl[6], 1'b1);

        for (int t = 0; t < 40; t++) begin
            int k;
            int bytes;
            bit aligned;
            k = $urandom_range(0, 2);
            bytes = 1 << k;
            rv.idx  = $urandom_range(0, NI - 1);
            rv.we   = 1'($urandom);
            rv.sg   = 1'($urandom);
            rv.wd   = (k == 2);
            rv.hf   = (k == 1);
            rv.lb   = 2'($urandom);
            rv.sdat = $urandom;
            rv.rdt  = $urandom;
            rv.ackd = $urandom_range(0, 3);
            aligned = (int'(rv.lb) % bytes) == 0;
            rv.exp_mis = (CS[rv.idx] != 0) && !aligned;
            rv.chk_sel = aligned;
            rv.exp_sel = 4'(((1 << bytes) - 1) << rv.lb);
            rv.exp_dat = rv.we ? 32'(rv.sdat << (8 * rv.lb))
                               : model_load(rv.rdt, rv.lb, bytes, rv.sg);
            run_op(rv, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
